// File: rtl/reg_operand_fetch_if.sv
// Decode->EX operand-fetch bus: instruction in, register-file read ports, writeback snoop, operands out.
// Latency: none (wires only).
// Backpressure: in_valid/in_ready toward decode, out_valid/out_ready from EX.
interface reg_operand_fetch_if #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32,
   parameter int INFO_W = 32
);
   // decoded instruction from decode
   logic              in_valid;
   logic              in_ready;
   logic [ADDR_W-1:0] in_rs1;
   logic [ADDR_W-1:0] in_rs2;
   logic              in_rs1_en;
   logic              in_rs2_en;
   logic [ADDR_W-1:0] in_rd;
   logic              in_rd_en;
   logic [INFO_W-1:0] in_info;

   // register-file read ports
   logic              read_enable1;
   logic              read_enable2;
   logic [ADDR_W-1:0] read_addr1;
   logic [ADDR_W-1:0] read_addr2;
   logic [DATA_W-1:0] read_data1;
   logic [DATA_W-1:0] read_data2;

   // writeback snoop
   logic              wb_enable;
   logic [ADDR_W-1:0] wb_addr;

   // operand bundle toward EX
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_op1;
   logic [DATA_W-1:0] out_op2;
   logic [ADDR_W-1:0] out_rd;
   logic              out_rd_en;
   logic [INFO_W-1:0] out_info;

   // operand-fetch block side
   modport slave (
      input  in_valid, in_rs1, in_rs2, in_rs1_en, in_rs2_en, in_rd, in_rd_en, in_info,
      output in_ready,
      output read_enable1, read_enable2, read_addr1, read_addr2,
      input  read_data1, read_data2,
      input  wb_enable, wb_addr,
      output out_valid, out_op1, out_op2, out_rd, out_rd_en, out_info,
      input  out_ready
   );

   // surrounding pipeline / register file side
   modport master (
      output in_valid, in_rs1, in_rs2, in_rs1_en, in_rs2_en, in_rd, in_rd_en, in_info,
      input  in_ready,
      input  read_enable1, read_enable2, read_addr1, read_addr2,
      output read_data1, read_data2,
      output wb_enable, wb_addr,
      input  out_valid, out_op1, out_op2, out_rd, out_rd_en, out_info,
      output out_ready
   );
endinterface

// File: rtl/reg_operand_fetch.sv
// Operand fetch with a 32-entry write scoreboard: holds one instruction, stalls on RAW, reads regfile, registers operands.
// Latency: accept at edge N, read ports driven in cycle N+1, bundle valid after edge N+1 if no hazard.
// Backpressure: in_ready drops while the slot is held and cannot issue; no issue while out_valid && !out_ready.
module reg_operand_fetch #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32,
   parameter int INFO_W = 32
) (
   input logic                clk,
   input logic                rst,
   reg_operand_fetch_if.slave bus
);

   localparam int NREG = 1 << ADDR_W;

   typedef enum logic {
      EMPTY = 1'b0,
      HELD  = 1'b1
   } slot_state_t;

   slot_state_t state;
   slot_state_t state_nxt;

   // holding slot
   logic [ADDR_W-1:0] s_rs1;
   logic [ADDR_W-1:0] s_rs2;
   logic              s_rs1_en;
   logic              s_rs2_en;
   logic [ADDR_W-1:0] s_rd;
   logic              s_rd_en;
   logic [INFO_W-1:0] s_info;

   // output register
   logic              o_valid;
   logic [DATA_W-1:0] o_op1;
   logic [DATA_W-1:0] o_op2;
   logic [ADDR_W-1:0] o_rd;
   logic              o_rd_en;
   logic [INFO_W-1:0] o_info;

   // pending-write scoreboard; entry 0 never set because x0 is hard-wired
   logic [NREG-1:0]   busy;
   logic [NREG-1:0]   busy_nxt;

   logic haz1;
   logic haz2;
   logic issue;
   logic in_rdy;
   logic accept;

   // Hazard/issue decision and slot next-state; the same-cycle writeback is covered by the regfile bypass
   always_comb begin
      state_nxt = state;
      haz1      = 1'b0;
      haz2      = 1'b0;
      issue     = 1'b0;
      in_rdy    = 1'b0;
      accept    = 1'b0;

      haz1 = s_rs1_en && (s_rs1 != '0) && busy[s_rs1] &&
             !(bus.wb_enable && (bus.wb_addr == s_rs1));
      haz2 = s_rs2_en && (s_rs2 != '0) && busy[s_rs2] &&
             !(bus.wb_enable && (bus.wb_addr == s_rs2));

      issue  = (state == HELD) && !haz1 && !haz2 && (!o_valid || bus.out_ready);
      in_rdy = !rst && ((state == EMPTY) || issue);
      accept = bus.in_valid && in_rdy;

      if (accept) begin
         state_nxt = HELD;
      end else if (issue) begin
         state_nxt = EMPTY;
      end
   end

   // Slot state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   // Capture the accepted instruction into the holding slot
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s_rs1    <= '0;
         s_rs2    <= '0;
         s_rs1_en <= 1'b0;
         s_rs2_en <= 1'b0;
         s_rd     <= '0;
         s_rd_en  <= 1'b0;
         s_info   <= '0;
      end else if (accept) begin
         s_rs1    <= bus.in_rs1;
         s_rs2    <= bus.in_rs2;
         s_rs1_en <= bus.in_rs1_en;
         s_rs2_en <= bus.in_rs2_en;
         s_rd     <= bus.in_rd;
         s_rd_en  <= bus.in_rd_en;
         s_info   <= bus.in_info;
      end
   end

   // Register-file read ports are only driven in the issue cycle so idle reads stay quiet
   always_comb begin
      bus.read_enable1 = 1'b0;
      bus.read_enable2 = 1'b0;
      bus.read_addr1   = '0;
      bus.read_addr2   = '0;
      if (issue) begin
         bus.read_enable1 = s_rs1_en;
         bus.read_enable2 = s_rs2_en;
         bus.read_addr1   = s_rs1;
         bus.read_addr2   = s_rs2;
      end
   end

   // Output register: load on issue, drop valid once EX takes it, hold steady otherwise
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o_valid <= 1'b0;
         o_op1   <= '0;
         o_op2   <= '0;
         o_rd    <= '0;
         o_rd_en <= 1'b0;
         o_info  <= '0;
      end else if (issue) begin
         o_valid <= 1'b1;
         o_op1   <= s_rs1_en ? bus.read_data1 : '0;
         o_op2   <= s_rs2_en ? bus.read_data2 : '0;
         o_rd    <= s_rd;
         o_rd_en <= s_rd_en;
         o_info  <= s_info;
      end else if (bus.out_ready) begin
         o_valid <= 1'b0;
      end
   end

   // Scoreboard update: writeback clears first so a same-cycle issue to that register leaves it busy
   always_comb begin
      busy_nxt = busy;
      if (bus.wb_enable && (bus.wb_addr != '0)) begin
         busy_nxt[bus.wb_addr] = 1'b0;
      end
      if (issue && s_rd_en && (s_rd != '0)) begin
         busy_nxt[s_rd] = 1'b1;
      end
      busy_nxt[0] = 1'b0;
   end

   // Scoreboard register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy <= '0;
      end else begin
         busy <= busy_nxt;
      end
   end

   assign bus.in_ready  = in_rdy;
   assign bus.out_valid = o_valid;
   assign bus.out_op1   = o_op1;
   assign bus.out_op2   = o_op2;
   assign bus.out_rd    = o_rd;
   assign bus.out_rd_en = o_rd_en;
   assign bus.out_info  = o_info;

endmodule

// File: tb/tb_reg_operand_fetch.sv
// Bench for reg_operand_fetch: directed scenarios with a register-file model and an expected-bundle queue.
// Latency: checks bundles as EX consumes them, one per out_valid && out_ready cycle.
// Backpressure: bench drives out_ready low to hold the output register.
module tb_reg_operand_fetch;

   logic clk;
   logic rst;

   reg_operand_fetch_if b ();

   reg_operand_fetch dut (
      .clk (clk),
      .rst (rst),
      .bus (b)
   );

   typedef struct packed {
      logic [31:0] op1;
      logic [31:0] op2;
      logic [4:0]  rd;
      logic        rd_en;
      logic [31:0] info;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] regs [32];
   logic [31:0] wb_data;
   int          checks;
   int          failures;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Register-file model: combinational read with same-cycle write bypass, x0 reads zero
   always_comb begin
      b.read_data1 = '0;
      b.read_data2 = '0;
      if (b.read_addr1 != 5'd0) begin
         b.read_data1 = (b.wb_enable && b.wb_addr == b.read_addr1) ? wb_data : regs[b.read_addr1];
      end
      if (b.read_addr2 != 5'd0) begin
         b.read_data2 = (b.wb_enable && b.wb_addr == b.read_addr2) ? wb_data : regs[b.read_addr2];
      end
   end

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      b.in_valid = 1'b0;
   endtask

   // Present an instruction, wait (bounded) for in_ready, then queue its expected bundle.
   // Acceptance happens at the next rising edge; the caller ticks.
   task automatic send(input logic [4:0] rs1, input logic e1, input logic [4:0] rs2, input logic e2,
                       input logic [4:0] rd, input logic rde, input logic [31:0] info,
                       input logic [31:0] x1, input logic [31:0] x2);
      int   n;
      exp_t e;
      n           = 0;
      b.in_valid  = 1'b1;
      b.in_rs1    = rs1;
      b.in_rs1_en = e1;
      b.in_rs2    = rs2;
      b.in_rs2_en = e2;
      b.in_rd     = rd;
      b.in_rd_en  = rde;
      b.in_info   = info;
      #1;
      while (!b.in_ready && n < 40) begin
         tick();
         n++;
      end
      if (n >= 40) chk("accept_timeout", 64'd0, 64'd1);
      e.op1   = x1;
      e.op2   = x2;
      e.rd    = rd;
      e.rd_en = rde;
      e.info  = info;
      sb.push_back(e);
   endtask

   // One-cycle writeback; the model register updates after the edge
   task automatic wb(input logic [4:0] a, input logic [31:0] d);
      b.wb_enable = 1'b1;
      b.wb_addr   = a;
      wb_data     = d;
      tick();
      if (a != 5'd0) regs[a] = d;
      b.wb_enable = 1'b0;
   endtask

   // Consumer side: every accepted bundle is compared against the oldest queued expectation
   always @(negedge clk) begin
      exp_t e;
      if (!rst && b.out_valid && b.out_ready) begin
         if (sb.size() == 0) begin
            chk("sb_underflow", 64'd1, 64'd0);
         end else begin
            e = sb.pop_front();
            chk("out_op1", b.out_op1, e.op1);
            chk("out_op2", b.out_op2, e.op2);
            chk("out_rd", b.out_rd, e.rd);
            chk("out_rd_en", b.out_rd_en, e.rd_en);
            chk("out_info", b.out_info, e.info);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog_timeout");
      $fatal(1);
   end

   initial begin
      checks      = 0;
      failures    = 0;
      rst         = 1'b1;
      b.in_valid  = 1'b0;
      b.in_rs1    = '0;
      b.in_rs2    = '0;
      b.in_rs1_en = 1'b0;
      b.in_rs2_en = 1'b0;
      b.in_rd     = '0;
      b.in_rd_en  = 1'b0;
      b.in_info   = '0;
      b.wb_enable = 1'b0;
      b.wb_addr   = '0;
      b.out_ready = 1'b1;
      wb_data     = '0;
      for (int i = 0; i < 32; i++) regs[i] = 32'h1000 + i;
      regs[0]  = 32'h0;
      regs[1]  = 32'h1;
      regs[4]  = 32'h10;
      regs[5]  = 32'h20;
      regs[12] = 32'hC0C0;

      // reset state
      tick();
      chk("rst_in_ready", b.in_ready, 0);
      chk("rst_out_valid", b.out_valid, 0);
      chk("rst_ren1", b.read_enable1, 0);
      chk("rst_raddr1", b.read_addr1, 0);
      chk("rst_busy", dut.busy, 0);
      chk("rst_op1", b.out_op1, 0);
      chk("rst_rd_en", b.out_rd_en, 0);
      tick();
      #2 rst = 1'b0;
      #1 chk("rst_rel_rdy", b.in_ready, 1);
      tick();

      // back-to-back independent instructions
      send(5'd1, 1, 5'd2, 0, 5'd3, 1, 32'hA1, 32'h1, 32'h0);
      tick();
      send(5'd4, 1, 5'd5, 1, 5'd6, 1, 32'hB2, 32'h10, 32'h20);
      chk("b2b_rdy", b.in_ready, 1);
      chk("b2b_ren1_a", b.read_enable1, 1);
      chk("b2b_raddr1_a", b.read_addr1, 1);
      tick();
      idle();
      #1;
      chk("b2b_ov_a", b.out_valid, 1);
      chk("b2b_raddr1_b", b.read_addr1, 4);
      chk("b2b_raddr2_b", b.read_addr2, 5);
      tick();
      chk("b2b_ov_b", b.out_valid, 1);
      tick();
      chk("b2b_ov_drop", b.out_valid, 0);
      wb(5'd3, 32'h33);
      wb(5'd6, 32'h66);
      chk("b2b_busy_clr", dut.busy, 0);

      // RAW stall released by same-cycle writeback
      send(5'd1, 1, 5'd0, 0, 5'd7, 1, 32'hC1, 32'h1, 32'h0);
      tick();
      send(5'd7, 1, 5'd0, 0, 5'd8, 1, 32'hC2, 32'hDEAD, 32'h0);
      tick();
      idle();
      #1;
      chk("raw_rdy", b.in_ready, 0);
      chk("raw_ren1", b.read_enable1, 0);
      tick();
      chk("raw_rdy2", b.in_ready, 0);
      chk("raw_busy7", dut.busy[7], 1);
      b.wb_enable = 1'b1;
      b.wb_addr   = 5'd7;
      wb_data     = 32'hDEAD;
      #1;
      chk("raw_rel_ren1", b.read_enable1, 1);
      chk("raw_rel_raddr1", b.read_addr1, 7);
      tick();
      regs[7]     = 32'hDEAD;
      b.wb_enable = 1'b0;
      chk("raw_ov", b.out_valid, 1);
      chk("raw_busy7_clr", dut.busy[7], 0);
      tick();
      wb(5'd8, 32'h88);

      // x0 as destination and source
      send(5'd1, 1, 5'd0, 0, 5'd0, 1, 32'hD1, 32'h1, 32'h0);
      tick();
      send(5'd0, 1, 5'd0, 1, 5'd0, 1, 32'hD2, 32'h0, 32'h0);
      chk("x0_rdy", b.in_ready, 1);
      tick();
      idle();
      #1;
      chk("x0_ren1", b.read_enable1, 1);
      tick();
      tick();
      chk("x0_busy", dut.busy, 0);

      // same-cycle set and clear of one register: set wins
      send(5'd1, 1, 5'd0, 0, 5'd9, 1, 32'hE1, 32'h1, 32'h0);
      tick();
      idle();
      tick();
      chk("sc_busy9_set", dut.busy[9], 1);
      send(5'd1, 1, 5'd0, 0, 5'd9, 1, 32'hE2, 32'h1, 32'h0);
      tick();
      idle();
      b.wb_enable = 1'b1;
      b.wb_addr   = 5'd9;
      wb_data     = 32'h99;
      #1;
      chk("sc_issue", b.read_enable1, 1);
      tick();
      regs[9]     = 32'h99;
      b.wb_enable = 1'b0;
      chk("sc_busy9_kept", dut.busy[9], 1);
      send(5'd9, 1, 5'd0, 0, 5'd0, 0, 32'hE3, 32'h77, 32'h0);
      tick();
      idle();
      #1;
      chk("sc_stall_rdy", b.in_ready, 0);
      chk("sc_stall_ren1", b.read_enable1, 0);
      tick();
      b.wb_enable = 1'b1;
      b.wb_addr   = 5'd9;
      wb_data     = 32'h77;
      #1;
      chk("sc_rel_ren1", b.read_enable1, 1);
      tick();
      regs[9]     = 32'h77;
      b.wb_enable = 1'b0;
      tick();
      chk("sc_busy_final", dut.busy, 0);

      // output backpressure
      b.out_ready = 1'b0;
      send(5'd4, 1, 5'd5, 1, 5'd0, 0, 32'hF1, 32'h10, 32'h20);
      tick();
      send(5'd1, 1, 5'd0, 0, 5'd0, 0, 32'hF2, 32'h1, 32'h0);
      tick();
      idle();
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("bp_rdy", b.in_ready, 0);
         chk("bp_ov", b.out_valid, 1);
         chk("bp_info", b.out_info, 32'hF1);
         chk("bp_op1", b.out_op1, 32'h10);
         chk("bp_ren1", b.read_enable1, 0);
         tick();
      end
      b.out_ready = 1'b1;
      #1;
      chk("bp_rel_ren1", b.read_enable1, 1);
      chk("bp_rel_raddr1", b.read_addr1, 1);
      tick();
      chk("bp_next_info", b.out_info, 32'hF2);
      tick();
      tick();

      // asynchronous reset with a held output and a stalled instruction
      b.out_ready = 1'b0;
      send(5'd1, 1, 5'd0, 0, 5'd12, 1, 32'hA7, 32'h1, 32'h0);
      tick();
      idle();
      tick();
      send(5'd12, 1, 5'd0, 0, 5'd0, 0, 32'hA8, 32'hC0C0, 32'h0);
      tick();
      idle();
      #1;
      chk("pre_rst_ov", b.out_valid, 1);
      chk("pre_rst_ren1", b.read_enable1, 0);
      #1 rst = 1'b1;
      #1;
      chk("arst_ov", b.out_valid, 0);
      chk("arst_busy", dut.busy, 0);
      chk("arst_rdy", b.in_ready, 0);
      chk("arst_info", b.out_info, 0);
      sb.delete();
      b.out_ready = 1'b1;
      tick();
      #2 rst = 1'b0;
      #1 chk("arst_rel_rdy", b.in_ready, 1);
      tick();
      send(5'd12, 1, 5'd0, 0, 5'd0, 0, 32'hA9, 32'hC0C0, 32'h0);
      tick();
      idle();
      #1;
      chk("arst_nostall_ren1", b.read_enable1, 1);
      chk("arst_nostall_raddr1", b.read_addr1, 12);
      tick();
      chk("arst_ov2", b.out_valid, 1);
      tick();
      tick();
      chk("sb_empty", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
